// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary: hazard/redirect controls, instruction-memory port mem1, IF/ID register outputs.
// master = fetch stage, slave = surrounding pipeline and instruction memory.
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] mem1_address;
    logic        mem1_read;
    logic        mem1_resp;
    logic [15:0] mem1_rdata;
    logic        ifid_valid;
    logic [15:0] ifid_ir;
    logic [15:0] ifid_pc;
    logic [3:0]  ifid_opcode;
    logic [11:0] ifid_irbits;

    modport master (
        input  stall, redirect, redirect_pc, mem1_resp, mem1_rdata,
        output mem1_address, mem1_read,
        output ifid_valid, ifid_ir, ifid_pc, ifid_opcode, ifid_irbits
    );

    modport slave (
        output stall, redirect, redirect_pc, mem1_resp, mem1_rdata,
        input  mem1_address, mem1_read,
        input  ifid_valid, ifid_ir, ifid_pc, ifid_opcode, ifid_irbits
    );
endinterface

// File: rtl/fetch_stage.sv
// LC-3b instruction fetch: owns the PC, drives mem1 and holds the IF/ID register.
// One instruction per cycle with zero-wait memory; a response arriving under stall is parked in a one-entry buffer.
module fetch_stage #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        DISCARD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [15:0] buf_ir;
    logic [15:0] buf_pc;
    logic [15:0] pending;
    logic        ifid_valid_r;
    logic [15:0] ifid_ir_r;
    logic [15:0] ifid_pc_r;

    assign pc_inc = pc + 16'd2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (bus.mem1_resp) begin
                    if (!bus.redirect && bus.stall) begin
                        state_nxt = BUFFERED;
                    end
                end else if (bus.redirect) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (bus.mem1_resp) begin
                    state_nxt = FETCH;
                end
            end
            BUFFERED: begin
                if (bus.redirect || !bus.stall) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // An abandoned read in DISCARD stays on the bus at its old address until memory answers.
    always_comb begin
        bus.mem1_read    = 1'b0;
        bus.mem1_address = pc;
        if (!reset) begin
            case (state)
                FETCH:    bus.mem1_read = 1'b1;
                DISCARD:  bus.mem1_read = 1'b1;
                default:  bus.mem1_read = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= PC_RESET;
            buf_ir       <= 16'h0000;
            buf_pc       <= 16'h0000;
            pending      <= 16'h0000;
            ifid_valid_r <= 1'b0;
            ifid_ir_r    <= 16'h0000;
            ifid_pc_r    <= 16'h0000;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.mem1_resp) begin
                        if (bus.redirect) begin
                            pc           <= bus.redirect_pc;
                            ifid_valid_r <= 1'b0;
                        end else if (!bus.stall) begin
                            ifid_valid_r <= 1'b1;
                            ifid_ir_r    <= bus.mem1_rdata;
                            ifid_pc_r    <= pc_inc;
                            pc           <= pc_inc;
                        end else begin
                            buf_ir <= bus.mem1_rdata;
                            buf_pc <= pc_inc;
                            pc     <= pc_inc;
                        end
                    end else if (bus.redirect) begin
                        pending      <= bus.redirect_pc;
                        ifid_valid_r <= 1'b0;
                    end else if (!bus.stall) begin
                        ifid_valid_r <= 1'b0;
                    end
                end
                DISCARD: begin
                    ifid_valid_r <= 1'b0;
                    if (bus.redirect) begin
                        pending <= bus.redirect_pc;
                    end
                    if (bus.mem1_resp) begin
                        pc <= bus.redirect ? bus.redirect_pc : pending;
                    end
                end
                BUFFERED: begin
                    if (bus.redirect) begin
                        pc           <= bus.redirect_pc;
                        ifid_valid_r <= 1'b0;
                    end else if (!bus.stall) begin
                        ifid_valid_r <= 1'b1;
                        ifid_ir_r    <= buf_ir;
                        ifid_pc_r    <= buf_pc;
                    end
                end
                default: ifid_valid_r <= 1'b0;
            endcase
        end
    end

    assign bus.ifid_valid  = ifid_valid_r;
    assign bus.ifid_ir     = ifid_ir_r;
    assign bus.ifid_pc     = ifid_pc_r;
    assign bus.ifid_opcode = ifid_ir_r[15:12];
    assign bus.ifid_irbits = ifid_ir_r[11:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: cycle table plus instruction scoreboard, and a second
// instance with PC_RESET=0xFFFE for address wrap.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if bus ();
    fetch_stage_if bus2 ();

    fetch_stage #(.PC_RESET(16'h0000)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    fetch_stage #(.PC_RESET(16'hFFFE)) dut_wrap (
        .clk   (clk),
        .reset (rst2),
        .bus   (bus2)
    );

    typedef struct {
        bit          rst;
        bit          stall;
        bit          redir;
        logic [15:0] rpc;
        int          lat;
        bit          exp_read;
        logic [15:0] exp_addr;
        bit          push;
        bit          exp_valid;
    } vec_t;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
    } instr_t;

    vec_t   vecs[$];
    instr_t sb[$];
    int     n_chk  = 0;
    int     n_fail = 0;
    int     cnt    = 0;

    function automatic vec_t mk(bit r, bit s, bit d, logic [15:0] rpc, int lat,
                                bit er, logic [15:0] ea, bit p, bit ev);
        vec_t v;
        v.rst = r; v.stall = s; v.redir = d; v.rpc = rpc; v.lat = lat;
        v.exp_read = er; v.exp_addr = ea; v.push = p; v.exp_valid = ev;
        return v;
    endfunction

    function automatic logic [15:0] memword(logic [15:0] a);
        case (a)
            16'h0000: return 16'h1234;
            16'h0002: return 16'h5678;
            16'h0004: return 16'hABCD;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    task automatic chk(string name, int row, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        instr_t e;
        logic [15:0] h_ir, h_pc;
        logic        h_v;

        bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 16'h0000;
        bus.mem1_resp = 0; bus.mem1_rdata = 16'h0000;
        bus2.stall = 0; bus2.redirect = 0; bus2.redirect_pc = 16'h0000;
        bus2.mem1_resp = 0; bus2.mem1_rdata = 16'h0000;

        //           rst st rd rpc       lat rd  addr      push valid
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0002, 1, 1));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0004, 1, 1));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0006, 1, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 2, 1, 16'h0008, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0040, 2, 1, 16'h0008, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 2, 1, 16'h0008, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 2, 1, 16'h0040, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 2, 1, 16'h0040, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 2, 1, 16'h0040, 1, 1));
        vecs.push_back(mk(0, 1, 1, 16'h0080, 0, 1, 16'h0042, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0080, 1, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 3, 1, 16'h0082, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0100, 3, 1, 16'h0082, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0200, 3, 1, 16'h0082, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 3, 1, 16'h0082, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0200, 1, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 2, 1, 16'h0202, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0100, 2, 1, 16'h0202, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 2, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 2, 1, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 1));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0002, 0, 1));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 1));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0002, 0, 1));
        vecs.push_back(mk(0, 1, 1, 16'h0300, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0300, 1, 1));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 2, 1, 16'h0302, 0, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 2, 1, 16'h0302, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 2, 1, 16'h0302, 1, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            bus.stall = vecs[i].stall;
            bus.redirect = vecs[i].redir;
            bus.redirect_pc = vecs[i].rpc;
            #1;
            chk("mem1_read", i, {15'd0, bus.mem1_read}, {15'd0, vecs[i].exp_read});
            if (vecs[i].exp_read)
                chk("mem1_address", i, bus.mem1_address, vecs[i].exp_addr);
            // Memory model: answer once the request has been held for lat cycles.
            if (bus.mem1_read && cnt >= vecs[i].lat) begin
                bus.mem1_resp = 1'b1;
                bus.mem1_rdata = memword(bus.mem1_address);
                cnt = 0;
            end else begin
                bus.mem1_resp = 1'b0;
                bus.mem1_rdata = 16'hDEAD;
                cnt = bus.mem1_read ? cnt + 1 : 0;
            end
            if (vecs[i].push) begin
                e.ir = memword(vecs[i].exp_addr);
                e.pc = vecs[i].exp_addr + 16'd2;
                sb.push_back(e);
            end
            h_v = bus.ifid_valid; h_ir = bus.ifid_ir; h_pc = bus.ifid_pc;
            @(posedge clk);
            #2;
            chk("ifid_valid", i, {15'd0, bus.ifid_valid}, {15'd0, vecs[i].exp_valid});
            if (!vecs[i].rst && !vecs[i].stall && bus.ifid_valid) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_instr (row %0d): got ir=%h pc=%h, expected none",
                             i, bus.ifid_ir, bus.ifid_pc);
                end else begin
                    e = sb.pop_front();
                    chk("ifid_ir", i, bus.ifid_ir, e.ir);
                    chk("ifid_pc", i, bus.ifid_pc, e.pc);
                    chk("ifid_opcode", i, {12'd0, bus.ifid_opcode}, {12'd0, e.ir[15:12]});
                    chk("ifid_irbits", i, {4'd0, bus.ifid_irbits}, {4'd0, e.ir[11:0]});
                end
            end
            if (!vecs[i].rst && vecs[i].stall && !vecs[i].redir) begin
                chk("hold_valid", i, {15'd0, bus.ifid_valid}, {15'd0, h_v});
                chk("hold_ir", i, bus.ifid_ir, h_ir);
                chk("hold_pc", i, bus.ifid_pc, h_pc);
            end
        end
        chk("scoreboard_left", 99, sb.size(), 0);

        // PC_RESET = 0xFFFE: ifid_pc and the next request address wrap to 0x0000.
        @(negedge clk);
        rst2 = 1'b1;
        #1;
        chk("wrap_read_in_reset", 100, {15'd0, bus2.mem1_read}, 16'd0);
        @(posedge clk); #2;
        chk("wrap_valid_after_reset", 100, {15'd0, bus2.ifid_valid}, 16'd0);
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        chk("wrap_read", 101, {15'd0, bus2.mem1_read}, 16'd1);
        chk("wrap_addr0", 101, bus2.mem1_address, 16'hFFFE);
        bus2.mem1_resp = 1'b1;
        bus2.mem1_rdata = 16'h2ABC;
        @(posedge clk); #2;
        chk("wrap_valid", 101, {15'd0, bus2.ifid_valid}, 16'd1);
        chk("wrap_ir", 101, bus2.ifid_ir, 16'h2ABC);
        chk("wrap_pc", 101, bus2.ifid_pc, 16'h0000);
        chk("wrap_opcode", 101, {12'd0, bus2.ifid_opcode}, 16'h0002);
        chk("wrap_irbits", 101, {4'd0, bus2.ifid_irbits}, 16'h0ABC);
        @(negedge clk);
        bus2.mem1_resp = 1'b0;
        #1;
        chk("wrap_addr1", 102, bus2.mem1_address, 16'h0000);
        chk("wrap_read1", 102, {15'd0, bus2.mem1_read}, 16'd1);
        @(posedge clk); #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
